seg7_scan_display: RTL
======================

# seg7_scan_display

Output-side board peripheral for the Basys3 build. It drives the 4-digit multiplexed seven-segment display with a 16-bit hex value and per-digit decimal points, for example the PC or the current instruction field. Values are accepted on a one-cycle load strobe and applied only at frame boundaries, so a frame never mixes old and new digits. It runs on the board clock alongside the button-input logic that generates CPUCLK.

## Interface
Parameters:
- REFRESH_DIV, default 100000: board-clock cycles per digit slot (1 kHz digit rate at 100 MHz). Legal range is ≥2.

Ports:
- BasysCLK  in  1: board clock. The block has one clock.
- Reset  in  1: synchronous, active-high reset.
- Load  in  1: one-cycle strobe that captures Data and Dp.
- Data  in  16: hex value. [3:0] is the rightmost digit (digit 0); [15:12] is digit 3.
- Dp  in  4: decimal-point enables, one per digit. Bit i maps to digit i; 1 means lit.
- AN  out  4: anode enables, active-low. AN[i] selects digit i.
- SEG  out  7: segments a..g as SEG[0]..SEG[6], active-low.
- DP  out  1: decimal point, active-low.
- FrameDone  out  1: one-cycle pulse at each frame wrap.

## Operation
- Divider cnt counts 0..REFRESH_DIV-1. tick = (cnt == REFRESH_DIV-1). On tick, cnt ← 0 and digit ← digit+1 mod 4.
- Registers:
  - shown_data[15:0] and shown_dp[3:0] hold the value currently displayed.
  - pend_data, pend_dp and pend_valid hold a loaded value waiting for the next frame.
- Load without a wrap in the same cycle: pend ← {Data,Dp} and pend_valid ← 1. A later Load before the wrap overwrites pend; last-writer wins.
- Wrap is a tick with digit==3. On wrap:
  - If pend_valid, shown ← pend and pend_valid ← 0.
  - FrameDone ← 1 for one cycle.
- Load in the same cycle as a wrap: shown ← {Data,Dp} directly and pend_valid ← 0. The strobe's data beats any older pending value.
- Output registers update every cycle from the current digit and shown_*:
  - AN = ~(1<<digit).
  - SEG = hex pattern of nibble[digit].
  - DP = ~shown_dp[digit].
- Hex patterns use the standard a–g encoding for 0–F. Lowercase b and d are used so they do not look like 8 and 0.
- Reset mid-frame aborts the frame. All state returns to reset values and any pending load is discarded.

## Timing
- Reset values:
  - cnt=0, digit=0.
  - shown_*=0, pend_*=0, pend_valid=0.
  - AN=4'b1111, SEG=7'b1111111, DP=1, FrameDone=0.
- First cycle after Reset deasserts: AN=4'b1110 and SEG shows "0".
- Outputs are registered and lag the digit/shown state by one cycle.
- Each digit is lit for exactly REFRESH_DIV cycles. A frame is 4·REFRESH_DIV cycles.
- Load-to-display latency is at most 4·REFRESH_DIV+1 cycles. The new value first appears on digit 0 one cycle after the wrap.
- FrameDone is asserted on the cycle after the wrap tick. It coincides with the first output cycle of digit 0.

## Configuration
- SEG_LZ_BLANK_EN defined: leading-zero blanking is enabled.
  - Digit i (for i = 3, 2, 1) is blanked when nibble i and every higher nibble are 0 and shown_dp for those digits is 0.
  - A blanked digit has AN[i]=1, and SEG and DP are forced all-ones.
  - Digit 0 is never blanked.
  - The blank decision uses shown_* only, so it is stable within a frame.
- SEG_LZ_BLANK_EN undefined: all four digits are always driven.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS=4.
  - the 16-entry active-low segment pattern constant.
  - SEG_OFF=7'b1111111 and AN_OFF=4'b1111.
- Sub-module hex_to_seg7 is a combinational 4-bit to 7-bit active-low decoder indexed from the package table. It is instantiated once on the selected nibble.
- The divider, digit counter, shadow registers and output registers live in the top module.

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset held for 3 cycles, then released: AN=1111 during reset; the cycle after release gives AN=1110 and SEG=7'b1000000. Over 16 cycles AN rotates 1110→1101→1011→0111, 4 cycles each. FrameDone pulses at cycle 17.
- Load with Data=16'h1A3F and Dp=4'b0100 in mid-frame: the displayed value is unchanged until the wrap. Next frame:
  - digit 0 SEG=7'b0001110 (F);
  - digit 1 SEG=7'b0110000 (3);
  - digit 2 SEG=7'b0001000 (A) with DP=0;
  - digit 3 SEG=7'b1111001 (1).
- Two Loads in one frame (16'h1111, then 16'h2222): the next frame shows 2222 and 1111 never appears.
- Load 16'h00C5 in the same cycle as a wrap tick while 16'h9999 is pending: the frame that starts now shows 00C5, and pend_valid reads 0 afterwards.
- Reset asserted mid-frame with a load pending: outputs go to all-off, and after release the display shows 0000.
- With SEG_LZ_BLANK_EN defined, load 16'h0007: digits 3..1 have AN high and digit 0 shows 7. Load 16'h0000: only digit 0 lights, showing "0". Load 16'h0007 with Dp=4'b0010: digit 1 lights with SEG off and DP=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: digit count,
// active-low off codes and the hex-to-segment table (bit 0 = a .. bit 6 = g).
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low patterns; lowercase b and d keep them distinct from 8 and 0.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = seg_of(i_nib);

endmodule

// File: rtl/seg7_scan_display.sv
// 4-digit multiplexed seven-segment scanner with frame-aligned value updates.
// Optional leading-zero blanking is built when SEG_LZ_BLANK_EN is defined.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        BasysCLK,
  input  logic        Reset,
  input  logic        Load,
  input  logic [15:0] Data,
  input  logic [3:0]  Dp,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FrameDone
);

  localparam int              CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [1:0]      DIG_MAX = 2'(NUM_DIGITS - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_digit;
  logic [15:0]   r_shown_data;
  logic [3:0]    r_shown_dp;
  logic [15:0]   r_pend_data;
  logic [3:0]    r_pend_dp;
  logic          r_pend_valid;
  logic          r_wrap;

  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_fd;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nib;
  logic          w_dp_lit;
  logic [6:0]    w_seg;
  logic          w_seg_blank;
  logic          w_an_blank;

  assign w_tick   = (r_cnt == CNT_MAX);
  assign w_wrap   = w_tick && (r_digit == DIG_MAX);
  assign w_nib    = r_shown_data[{r_digit, 2'b00} +: 4];
  assign w_dp_lit = r_shown_dp[r_digit];

  hex_to_seg7 u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

`ifdef SEG_LZ_BLANK_EN
  // w_lz[i]: nibble i and all higher nibbles are zero; w_dpz[i]: same for dp bits.
  logic [3:0] w_lz;
  logic [3:0] w_dpz;

  always_comb begin
    w_lz  = 4'b0000;
    w_dpz = 4'b0000;
    w_lz[3]  = (r_shown_data[15:12] == 4'h0);
    w_dpz[3] = ~r_shown_dp[3];
    for (int i = 2; i >= 1; i--) begin
      w_lz[i]  = w_lz[i+1] && (r_shown_data[4*i +: 4] == 4'h0);
      w_dpz[i] = w_dpz[i+1] && ~r_shown_dp[i];
    end
  end

  assign w_seg_blank = w_lz[r_digit];
  assign w_an_blank  = w_lz[r_digit] && w_dpz[r_digit];
`else
  assign w_seg_blank = 1'b0;
  assign w_an_blank  = 1'b0;
`endif

  // Divider, digit counter and the pending/shown shadow pair.
  always_ff @(posedge BasysCLK) begin
    if (Reset) begin
      r_cnt        <= '0;
      r_digit      <= 2'd0;
      r_shown_data <= 16'h0000;
      r_shown_dp   <= 4'h0;
      r_pend_data  <= 16'h0000;
      r_pend_dp    <= 4'h0;
      r_pend_valid <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_wrap <= w_wrap;
      if (w_tick) begin
        r_cnt   <= '0;
        r_digit <= r_digit + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_wrap) begin
        r_pend_valid <= 1'b0;
        if (Load) begin
          r_shown_data <= Data;
          r_shown_dp   <= Dp;
        end else if (r_pend_valid) begin
          r_shown_data <= r_pend_data;
          r_shown_dp   <= r_pend_dp;
        end
      end else if (Load) begin
        r_pend_data  <= Data;
        r_pend_dp    <= Dp;
        r_pend_valid <= 1'b1;
      end
    end
  end

  // Output stage lags state by one cycle; FrameDone lines up with digit 0.
  always_ff @(posedge BasysCLK) begin
    if (Reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
      r_fd  <= 1'b0;
    end else begin
      r_an  <= w_an_blank  ? AN_OFF  : ~(4'b0001 << r_digit);
      r_seg <= w_seg_blank ? SEG_OFF : w_seg;
      r_dp  <= w_an_blank  ? 1'b1    : ~w_dp_lit;
      r_fd  <= r_wrap;
    end
  end

  assign AN        = r_an;
  assign SEG       = r_seg;
  assign DP        = r_dp;
  assign FrameDone = r_fd;

endmodule
